// File: rtl/mmio_bridge_pkg.sv
// Shared constants for the MMIO bridge: I/O decode prefix, register offsets, STATUS bit layout.
package mmio_bridge_pkg;

  localparam logic [1:0] IO_PREFIX  = 2'b11;

  localparam logic [3:0] OFF_KBD    = 4'd8;
  localparam logic [3:0] OFF_STATUS = 4'd9;

  localparam int unsigned ST_EMPTY  = 0;
  localparam int unsigned ST_FULL   = 1;
  localparam int unsigned ST_OVF    = 2;
  localparam int unsigned ST_IRQ_EN = 3;
  localparam int unsigned ST_COUNT  = 8;
  localparam int unsigned ST_WIDTH  = 16;

endpackage

// File: rtl/kbd_fifo.sv
// Keyboard scancode FIFO: power-of-two depth, wrapping pointers, sticky overflow.
// A push while full is accepted only when a pop happens in the same cycle.
module kbd_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DW-1:0]            din,
  input  logic                     pop,
  input  logic                     ovf_clr,
  output logic [DW-1:0]            head_c,
  output logic                     empty_c,
  output logic                     full_c,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          pop_ok;
  logic          push_ok;

  assign empty_c = (count == '0);
  assign full_c  = (count == CW'(DEPTH));
  assign head_c  = mem[rd_ptr];
  assign pop_ok  = pop & ~empty_c;
  assign push_ok = push & (~full_c | pop_ok);

  // Pointer, occupancy and overflow bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push & ~push_ok) ovf <= 1'b1;
      else if (ovf_clr)    ovf <= 1'b0;
    end
  end

  // Storage array; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mmio_bridge.sv
// CPU MMIO bridge: BRAM pass-through below the I/O region, output registers,
// keyboard FIFO and STATUS register inside it.
// Optional feature macro: MMIO_BRIDGE_IRQ_EN (keyboard interrupt and writable irq_en).
module mmio_bridge
  import mmio_bridge_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned N_OUT      = 2,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_WIDTH-1:0]    cpu_addr,
  input  logic                     cpu_we,
  input  logic                     cpu_re,
  input  logic [WIDTH-1:0]         cpu_wdata,
  output logic [WIDTH-1:0]         cpu_rdata,
  output logic                     mem_we,
  input  logic [WIDTH-1:0]         mem_q,
  input  logic [7:0]               kb_data,
  input  logic                     kb_valid,
  output logic [N_OUT*WIDTH-1:0]   out_regs,
  output logic                     irq
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic             io;
  logic [3:0]       off;
  logic             io_wr;
  logic             io_rd;
  logic             kb_pop;
  logic             st_wr;
  logic [7:0]       kb_head_c;
  logic             kb_empty_c;
  logic             kb_full_c;
  logic [CW-1:0]    kb_count;
  logic             kb_ovf;
  logic             irq_en;
  logic [ST_WIDTH-1:0] status_c;
  logic [WIDTH-1:0] io_rdata_c;
  logic [WIDTH-1:0] io_rdata_q;
  logic             io_sel_q;
  logic             unused_addr;

  assign io          = (cpu_addr[ADDR_WIDTH-1 -: 2] == IO_PREFIX);
  assign off         = cpu_addr[3:0];
  assign unused_addr = ^cpu_addr[ADDR_WIDTH-3:4];
  assign mem_we      = cpu_we & ~io;
  assign io_wr       = cpu_we & io;
  assign io_rd       = cpu_re & io;
  assign kb_pop      = io_rd & (off == OFF_KBD);
  assign st_wr       = io_wr & (off == OFF_STATUS);

  kbd_fifo #(
    .DW    (8),
    .DEPTH (FIFO_DEPTH)
  ) u_kbd_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (kb_valid),
    .din     (kb_data),
    .pop     (kb_pop),
    .ovf_clr (st_wr),
    .head_c  (kb_head_c),
    .empty_c (kb_empty_c),
    .full_c  (kb_full_c),
    .count   (kb_count),
    .ovf     (kb_ovf)
  );

  // Output channel registers, loaded by I/O writes to offsets 0..N_OUT-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_regs <= '0;
    end else begin
      for (int unsigned i = 0; i < N_OUT; i++) begin
        if (io_wr && (off == 4'(i))) out_regs[i*WIDTH +: WIDTH] <= cpu_wdata;
      end
    end
  end

`ifdef MMIO_BRIDGE_IRQ_EN
  // Interrupt enable and registered data-available interrupt.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (st_wr) irq_en <= cpu_wdata[ST_IRQ_EN];
      irq <= irq_en & ~kb_empty_c;
    end
  end
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

  // STATUS register image.
  always_comb begin
    status_c              = '0;
    status_c[ST_EMPTY]    = kb_empty_c;
    status_c[ST_FULL]     = kb_full_c;
    status_c[ST_OVF]      = kb_ovf;
    status_c[ST_IRQ_EN]   = irq_en;
    status_c[ST_COUNT +: 8] = 8'(kb_count);
  end

  // I/O read mux; uses pre-write register values so same-cycle read-write returns old data.
  always_comb begin
    io_rdata_c = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      if (off == 4'(i)) io_rdata_c = out_regs[i*WIDTH +: WIDTH];
    end
    if (off == OFF_KBD)         io_rdata_c = kb_empty_c ? '0 : WIDTH'(kb_head_c);
    else if (off == OFF_STATUS) io_rdata_c = WIDTH'(status_c);
  end

  // One-cycle read pipeline register for the I/O path and region select.
  always_ff @(posedge clk) begin
    if (reset) begin
      io_sel_q   <= 1'b0;
      io_rdata_q <= '0;
    end else if (cpu_re) begin
      io_sel_q   <= io;
      io_rdata_q <= io ? io_rdata_c : '0;
    end
  end

  assign cpu_rdata = io_sel_q ? io_rdata_q : mem_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge: queue-based model plus directed literal checks.
module tb_mmio_bridge;

  localparam int DEPTH = 8;
`ifdef MMIO_BRIDGE_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif
  localparam logic [15:0] IRQB = IRQ_ON ? 16'h0008 : 16'h0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  cpu_addr = '0;
  logic        cpu_we = 1'b0;
  logic        cpu_re = 1'b0;
  logic [15:0] cpu_wdata = '0;
  logic [15:0] cpu_rdata;
  logic        mem_we;
  logic [15:0] mem_q = '0;
  logic [7:0]  kb_data = '0;
  logic        kb_valid = 1'b0;
  logic [31:0] out_regs;
  logic        irq;

  int passed = 0;
  int total  = 0;

  mmio_bridge dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_we    (cpu_we),
    .cpu_re    (cpu_re),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .mem_we    (mem_we),
    .mem_q     (mem_q),
    .kb_data   (kb_data),
    .kb_valid  (kb_valid),
    .out_regs  (out_regs),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Simple BRAM on port A: read-before-write, one cycle latency.
  logic [15:0] bram [1024];
  initial for (int i = 0; i < 1024; i++) bram[i] = '0;
  always @(posedge clk) begin
    mem_q <= bram[cpu_addr];
    if (mem_we) bram[cpu_addr] <= cpu_wdata;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  // Behavioural model of the register map and keyboard queue.
  logic [15:0] m_out [2];
  logic [7:0]  m_q [$];
  bit          m_ovf, m_irqen, m_irq, m_rsel, m_chk_rd, started;
  logic [15:0] m_rdata;

  function automatic logic [15:0] model_read(input logic [3:0] off);
    logic [15:0] v;
    v = '0;
    if (off < 4'd2) v = m_out[off[0]];
    else if (off == 4'd8) v = (m_q.size() > 0) ? {8'h00, m_q[0]} : 16'h0000;
    else if (off == 4'd9) v = {8'(m_q.size()), 4'b0000, m_irqen, m_ovf,
                               m_q.size() == DEPTH, m_q.size() == 0};
    return v;
  endfunction

  always @(posedge clk) begin
    bit io, pop, nxt_irq;
    logic [3:0] off;
    started = 1'b1;
    if (reset) begin
      m_q.delete();
      m_out[0] = '0; m_out[1] = '0;
      m_ovf = 0; m_irqen = 0; m_irq = 0;
      m_rsel = 0; m_rdata = '0; m_chk_rd = 1;
    end else begin
      io = (cpu_addr[9:8] == 2'b11);
      off = cpu_addr[3:0];
      nxt_irq = IRQ_ON && m_irqen && (m_q.size() != 0);
      m_chk_rd = cpu_re;
      if (cpu_re) begin
        m_rsel = io;
        m_rdata = io ? model_read(off) : 16'h0000;
      end
      pop = cpu_re && io && off == 4'd8 && m_q.size() > 0;
      if (cpu_we && io) begin
        if (off < 4'd2) m_out[off[0]] = cpu_wdata;
        if (off == 4'd9) begin
          m_ovf = 0;
          if (IRQ_ON) m_irqen = cpu_wdata[3];
        end
      end
      if (pop) void'(m_q.pop_front());
      if (kb_valid) begin
        if (m_q.size() < DEPTH) m_q.push_back(kb_data);
        else m_ovf = 1;
      end
      m_irq = nxt_irq;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("out_regs", out_regs, {m_out[1], m_out[0]});
      chk("irq", irq, m_irq);
      chk("mem_we", mem_we, cpu_we & ~(cpu_addr[9:8] == 2'b11));
      if (m_chk_rd) chk("cpu_rdata", cpu_rdata, m_rsel ? m_rdata : mem_q);
    end
  end

  task automatic cyc(input logic [9:0] a, input logic we, input logic re,
                     input logic [15:0] wd, input logic kv, input logic [7:0] kd);
    cpu_addr = a; cpu_we = we; cpu_re = re; cpu_wdata = wd; kb_valid = kv; kb_data = kd;
    @(posedge clk); #1;
    cpu_we = 0; cpu_re = 0; kb_valid = 0;
  endtask

  task automatic wr(input logic [9:0] a, input logic [15:0] d, input logic exp_we);
    cpu_addr = a; cpu_we = 1; cpu_wdata = d;
    #1 chk("mem_we_lit", mem_we, exp_we);
    @(posedge clk); #1;
    cpu_we = 0;
  endtask

  task automatic rd(input string name, input logic [9:0] a, input logic [15:0] exp);
    cyc(a, 0, 1, 16'h0, 0, 8'h0);
    chk(name, cpu_rdata, exp);
  endtask

  task automatic push(input logic [7:0] d);
    cyc(10'h000, 0, 0, 16'h0, 1, d);
  endtask

  task automatic idle();
    cyc(10'h000, 0, 0, 16'h0, 0, 8'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] drain [8];
    drain[0] = 8'h41; drain[1] = 8'h42; drain[2] = 8'h43; drain[3] = 8'h44;
    drain[4] = 8'h45; drain[5] = 8'h46; drain[6] = 8'h47; drain[7] = 8'h55;

    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("rst_out_regs", out_regs, 32'h0);
    chk("rst_irq", irq, 1'b0);
    rd("rst_status", 10'h309, 16'h0001);

    // Output registers.
    wr(10'h300, 16'h00A5, 1'b0);
    wr(10'h301, 16'h1234, 1'b0);
    chk("out_regs_lit", out_regs, 32'h1234_00A5);
    rd("rd_out1", 10'h301, 16'h1234);
    rd("rd_out0", 10'h300, 16'h00A5);
    cyc(10'h300, 1, 1, 16'h5555, 0, 8'h0);
    chk("rw_same_cycle", cpu_rdata, 16'h00A5);
    chk("rw_out_regs", out_regs, 32'h1234_5555);

    // BRAM path.
    wr(10'h010, 16'hBEEF, 1'b1);
    rd("rd_bram", 10'h010, 16'hBEEF);

    // Unmapped I/O offsets.
    rd("rd_unmapped5", 10'h305, 16'h0000);
    wr(10'h30A, 16'hFFFF, 1'b0);
    rd("rd_unmapped10", 10'h30A, 16'h0000);

    // Keyboard FIFO basic.
    push(8'h1C);
    push(8'h32);
    rd("status_two", 10'h309, 16'h0200);
    rd("kbd_first", 10'h308, 16'h001C);
    rd("kbd_second", 10'h308, 16'h0032);
    rd("status_empty", 10'h309, 16'h0001);
    rd("kbd_pop_empty", 10'h308, 16'h0000);
    rd("status_after_empty_pop", 10'h309, 16'h0001);

    // Overflow.
    for (int i = 0; i < 9; i++) push(8'(8'h40 + i));
    rd("status_ovf", 10'h309, 16'h0806);
    wr(10'h309, 16'h0000, 1'b0);
    rd("status_ovf_clr", 10'h309, 16'h0802);

    // Push and pop together while full.
    cyc(10'h308, 0, 1, 16'h0, 1, 8'h55);
    chk("full_pushpop_data", cpu_rdata, 16'h0040);
    rd("full_pushpop_status", 10'h309, 16'h0802);
    for (int i = 0; i < 8; i++) rd("drain", 10'h308, {8'h00, drain[i]});
    rd("status_drained", 10'h309, 16'h0001);

    // Push and pop together while empty.
    cyc(10'h308, 0, 1, 16'h0, 1, 8'h66);
    chk("empty_pushpop_data", cpu_rdata, 16'h0000);
    rd("empty_pushpop_status", 10'h309, 16'h0100);
    rd("kbd_66", 10'h308, 16'h0066);

    // Interrupt.
    wr(10'h309, 16'h0008, 1'b0);
    rd("status_irqen", 10'h309, 16'h0001 | IRQB);
    push(8'h5A);
    idle();
    chk("irq_set", irq, IRQ_ON);
    rd("kbd_5A", 10'h308, 16'h005A);
    idle();
    chk("irq_clr", irq, 1'b0);

    // Reset mid-transfer with data queued and a read pending.
    push(8'h77);
    idle();
    reset = 1;
    cyc(10'h308, 0, 1, 16'h0, 0, 8'h0);
    reset = 0;
    chk("mid_rst_irq", irq, 1'b0);
    chk("mid_rst_out", out_regs, 32'h0);
    chk("mid_rst_rdata", cpu_rdata, mem_q);
    rd("mid_rst_status", 10'h309, 16'h0001);
    rd("mid_rst_kbd", 10'h308, 16'h0000);
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
